// File: rtl/ws281x_pkg.sv
// Shared types for the ws281x pixel RAM arbiter.
// Holds default widths and the commit/swap FSM state encoding.
package ws281x_pkg;
   localparam int ADDR_W_DEF = 6;
   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      SWAP = 2'd2
   } arb_state_t;
endpackage

// File: rtl/ws281x_bank_sel.sv
// Front/back bank selector: front-bank toggle, frame_busy tracking and
// the commit FSM (IDLE/PEND/SWAP).
// Ports: clk_i, rst_i (sync, active high), wr_commit_i, rd_frame_done_i in;
//        front_o (front bank), idle_o (host writes allowed),
//        wr_done_o (1-cycle swap pulse), ovr_o (sticky commit overrun) out.
module ws281x_bank_sel
   import ws281x_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic wr_commit_i,
   input  logic rd_frame_done_i,
   output logic front_o,
   output logic idle_o,
   output logic wr_done_o,
   output logic ovr_o
);

   arb_state_t state_q, state_d;
   logic       front_q, front_d;
   logic       busy_q, busy_d;
   logic       ovr_q, ovr_d;
   logic       done;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         front_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         front_q <= front_d;
         busy_q  <= busy_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      front_d = front_q;
      busy_d  = busy_q;
      ovr_d   = ovr_q;
      done    = 1'b0;
      if (rd_frame_done_i)
         busy_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            // A frame ending in the same cycle as the commit frees the
            // reader right away, so no need to wait in PEND.
            if (wr_commit_i)
               state_d = (busy_q & ~rd_frame_done_i) ? PEND : SWAP;
         end
         PEND: begin
            if (wr_commit_i)
               ovr_d = 1'b1;
            if (rd_frame_done_i)
               state_d = SWAP;
         end
         SWAP: begin
            front_d = ~front_q;
            // Reader starts the new frame now; set beats a same-cycle clear.
            busy_d  = 1'b1;
            done    = 1'b1;
            if (wr_commit_i)
               ovr_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign front_o   = front_q;
   assign idle_o    = (state_q == IDLE);
   assign wr_done_o = done & ~rst_i;
   assign ovr_o     = ovr_q;

endmodule

// File: rtl/ws281x_ram_arb.sv
// Single-port pixel RAM arbiter with double-buffered banks: host writes
// the back bank, ws281x_ctrl reads the front bank; commits swap at frame end.
// Ports: host write (wr_vld_i/wr_rdy_o/wr_addr_i/wr_data_i/wr_commit_i),
//        reader (rd_en_i/rd_addr_i/rd_data_o/rd_frame_done_i/wr_done_o),
//        RAM (ram_en_o/ram_we_o/ram_addr_o/ram_wdata_o/ram_rdata_i), ovr_o.
module ws281x_ram_arb
   import ws281x_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              wr_vld_i,
   output logic              wr_rdy_o,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_commit_i,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   input  logic              rd_frame_done_i,
   output logic              wr_done_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic [ADDR_W:0]   ram_addr_o,
   output logic [DATA_W-1:0] ram_wdata_o,
   input  logic [DATA_W-1:0] ram_rdata_i,
   output logic              ovr_o
);

   logic front;
   logic idle;
   logic rd_go;
   logic wr_go;

   ws281x_bank_sel u_bank_sel (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .wr_commit_i     (wr_commit_i),
      .rd_frame_done_i (rd_frame_done_i),
      .front_o         (front),
      .idle_o          (idle),
      .wr_done_o       (wr_done_o),
      .ovr_o           (ovr_o)
   );

   assign rd_go    = rd_en_i & ~rst_i;
   assign wr_rdy_o = ~rd_en_i & idle & ~rst_i;
   assign wr_go    = wr_vld_i & wr_rdy_o;

   always_comb begin
      ram_en_o    = 1'b0;
      ram_we_o    = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (rd_go) begin
         ram_en_o   = 1'b1;
         ram_addr_o = {front, rd_addr_i};
      end else if (wr_go) begin
         ram_en_o    = 1'b1;
         ram_we_o    = 1'b1;
         ram_addr_o  = {~front, wr_addr_i};
         ram_wdata_o = wr_data_i;
      end
   end

   assign rd_data_o = ram_rdata_i;

endmodule

// File: tb/tb_ws281x_ram_arb.sv
// Self-checking bench for ws281x_ram_arb: directed scenarios then random
// traffic, checked cycle by cycle against a frame-level reference model.
module tb_ws281x_ram_arb;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        wr_vld_i = 1'b0;
   logic        wr_rdy_o;
   logic [5:0]  wr_addr_i = '0;
   logic [31:0] wr_data_i = '0;
   logic        wr_commit_i = 1'b0;
   logic        rd_en_i = 1'b0;
   logic [5:0]  rd_addr_i = '0;
   logic [31:0] rd_data_o;
   logic        rd_frame_done_i = 1'b0;
   logic        wr_done_o;
   logic        ram_en_o;
   logic        ram_we_o;
   logic [6:0]  ram_addr_o;
   logic [31:0] ram_wdata_o;
   logic [31:0] ram_rdata_i = '0;
   logic        ovr_o;

   always #5 clk = ~clk;

   ws281x_ram_arb dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .wr_vld_i        (wr_vld_i),
      .wr_rdy_o        (wr_rdy_o),
      .wr_addr_i       (wr_addr_i),
      .wr_data_i       (wr_data_i),
      .wr_commit_i     (wr_commit_i),
      .rd_en_i         (rd_en_i),
      .rd_addr_i       (rd_addr_i),
      .rd_data_o       (rd_data_o),
      .rd_frame_done_i (rd_frame_done_i),
      .wr_done_o       (wr_done_o),
      .ram_en_o        (ram_en_o),
      .ram_we_o        (ram_we_o),
      .ram_addr_o      (ram_addr_o),
      .ram_wdata_o     (ram_wdata_o),
      .ram_rdata_i     (ram_rdata_i),
      .ovr_o           (ovr_o)
   );

   // Physical RAM behind the arbiter, 1-cycle read latency.
   logic [31:0] ram [128];
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
         ram_rdata_i <= ram[ram_addr_o];
      end
   end

   // Reference model: what the host has written into each bank, which
   // bank the reader sees, and where the commit handshake stands.
   logic [31:0] img [2][64];
   int  m_front;
   bit  m_busy;
   bit  m_waiting;
   bit  m_swap_now;
   bit  m_ovr;
   bit  rd_prev;
   logic [31:0] rd_exp;
   int  n_vec = 0;
   int  n_err = 0;
   int  n_done = 0;
   int  accepts = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input bit rst, input bit rd, input int ra,
                       input bit wv, input int wa, input logic [31:0] wd,
                       input bit cm, input bit fd);
      bit rdy, done, wacc;
      logic [6:0] ea;
      rst_i = rst; rd_en_i = rd; rd_addr_i = 6'(ra);
      wr_vld_i = wv; wr_addr_i = 6'(wa); wr_data_i = wd;
      wr_commit_i = cm; rd_frame_done_i = fd;
      @(negedge clk);
      rdy  = !rst && !rd && !m_waiting && !m_swap_now;
      done = !rst && m_swap_now;
      wacc = wv && rdy;
      ea   = rd ? {1'(m_front), 6'(ra)} : {1'(1 - m_front), 6'(wa)};
      chk("wr_rdy", 64'(wr_rdy_o), 64'(rdy));
      chk("wr_done", 64'(wr_done_o), 64'(done));
      chk("ovr", 64'(ovr_o), 64'(m_ovr));
      chk("ram_en", 64'(ram_en_o), 64'(!rst && (rd || wacc)));
      chk("ram_we", 64'(ram_we_o), 64'(!rst && !rd && wacc));
      chk("ram_addr", 64'(ram_addr_o),
          (!rst && (rd || wacc)) ? 64'(ea) : 64'd0);
      chk("ram_wdata", 64'(ram_wdata_o), (!rst && !rd && wacc) ? 64'(wd) : 64'd0);
      if (rd_prev) chk("rd_data", 64'(rd_data_o), 64'(rd_exp));
      @(posedge clk);
      rd_prev = 1'b0;
      if (done) n_done++;
      if (rst) begin
         m_front = 0; m_busy = 0; m_waiting = 0; m_swap_now = 0; m_ovr = 0;
      end else begin
         if (rd) begin
            rd_prev = 1'b1;
            rd_exp = img[m_front][ra];
         end
         if (wacc) begin
            img[1 - m_front][wa] = wd;
            accepts++;
         end
         if (fd) m_busy = 0;
         if (m_swap_now) begin
            m_front = 1 - m_front;
            m_busy = 1;
            m_swap_now = 0;
            if (cm) m_ovr = 1;
         end else if (m_waiting) begin
            if (cm) m_ovr = 1;
            if (fd) begin m_waiting = 0; m_swap_now = 1; end
         end else if (cm) begin
            if (m_busy) m_waiting = 1;
            else m_swap_now = 1;
         end
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) ram[i] = '0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 64; i++) img[b][i] = '0;
      m_front = 0; m_busy = 0; m_waiting = 0; m_swap_now = 0; m_ovr = 0;
      rd_prev = 0; rd_exp = '0;
      #1;
      step(1, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 3, 1, 4, 32'h1234, 0, 0);
      idle(1);

      // Fill the back bank, one write per cycle.
      for (int i = 0; i < 64; i++)
         step(0, 0, 0, 1, i, 32'haaaa_cccc + 32'(i), 0, 0);
      chk("fill_accepts", 64'(accepts), 64'd64);

      // Commit with idle reader, then read back word 5 from bank 1.
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("done_after_commit", 64'(n_done), 64'd1);
      step(0, 1, 5, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rd5_data", 64'(rd_exp), 64'h aaaa_ccd1);

      // Reads starve writes, then writes drain.
      accepts = 0;
      for (int i = 0; i < 10; i++)
         step(0, 1, i, 1, i, 32'h5500_0000 + 32'(i), 0, 0);
      chk("starved", 64'(accepts), 64'd0);
      for (int i = 0; i < 10; i++)
         step(0, 0, 0, 1, i, 32'h5500_0000 + 32'(i), 0, 0);
      chk("drained", 64'(accepts), 64'd10);

      // Commit while reader busy: pend, second commit overruns.
      n_done = 0;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 7, 32'hdead, 0, 0);
      step(0, 0, 0, 1, 7, 32'hdead, 1, 0);
      idle(3);
      step(0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      chk("pend_one_done", 64'(n_done), 64'd1);

      // Commit coinciding with frame end goes straight to swap.
      n_done = 0;
      step(0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("direct_swap", 64'(n_done), 64'd1);

      // Reset while pending discards the commit.
      n_done = 0;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      step(0, 1, 5, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rst_no_done", 64'(n_done), 64'd0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(199) == 0, $urandom_range(9) < 3,
              int'($urandom_range(63)), $urandom_range(9) < 6,
              int'($urandom_range(63)), $urandom,
              $urandom_range(19) == 0, $urandom_range(19) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ws281x_ram_arb.md
Name: ws281x_ram_arb

Overview:
- Owns the single-port pixel RAM between the host write path and ws281x_ctrl's read path.
- Double-buffers the RAM as two banks: the host fills the back bank while ws281x_ctrl streams the front bank.
- A host frame commit swaps the banks only at a ws281x frame boundary, then pulses wr_done_o to start ws281x_ctrl on the new frame.

Parameters:
- ADDR_W, 6, word address width per bank; matches ws281x_ctrl rd_addr_o.
- DATA_W, 32, pixel word width.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- wr_vld_i  in  1  host write request
- wr_rdy_o  out  1  host write accepted this cycle when wr_vld_i & wr_rdy_o
- wr_addr_i  in  ADDR_W  host word address, back bank
- wr_data_i  in  DATA_W  host write data
- wr_commit_i  in  1  pulse: back bank holds a complete frame
- rd_en_i  in  1  ws281x_ctrl read request, front bank; never stalled
- rd_addr_i  in  ADDR_W  ws281x_ctrl read address
- rd_data_o  out  DATA_W  read data, valid 1 cycle after rd_en_i
- rd_frame_done_i  in  1  pulse from ws281x_ctrl: last bit plus reset gap sent
- wr_done_o  out  1  1-cycle pulse: new front bank ready; drives ws281x_ctrl wr_done_i
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write enable
- ram_addr_o  out  ADDR_W+1  {bank, word address}
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, 1-cycle latency
- ovr_o  out  1  sticky: commit arrived while a swap was pending

Behaviour:
- Reset values and state:
  - front bank = 0, back bank = 1.
  - wr_done_o=0, ovr_o=0, frame_busy=0.
  - State IDLE; all ram_* outputs 0.
- Arbitration (combinational, single port):
  - rd_en_i has strict priority: ram_en_o=1, ram_we_o=0, ram_addr_o={front, rd_addr_i}.
  - Otherwise, if wr_vld_i & wr_rdy_o: ram_en_o=1, ram_we_o=1, ram_addr_o={back, wr_addr_i}, ram_wdata_o=wr_data_i.
  - wr_rdy_o = ~rd_en_i & (state==IDLE) & ~rst_i.
- rd_data_o = ram_rdata_i passthrough. The bank used for a read is the front bank in the cycle rd_en_i was sampled.
- frame_busy:
  - Set the cycle after wr_done_o pulses.
  - Cleared on rd_frame_done_i.
  - If both occur in the same cycle, set wins.
- State machine:
  - IDLE:
    - wr_commit_i & ~frame_busy -> SWAP.
    - wr_commit_i & frame_busy -> PEND.
  - PEND: host writes blocked (wr_rdy_o=0); rd_frame_done_i -> SWAP.
  - SWAP (exactly 1 cycle):
    - Toggle front/back.
    - wr_done_o=1 this cycle.
    - -> IDLE.
- Commit latency:
  - Idle reader: wr_commit_i at cycle N -> SWAP at N+1, wr_done_o high in N+1.
  - Pending: rd_frame_done_i at cycle M -> wr_done_o at M+1.
- Boundary conditions:
  - wr_commit_i and rd_frame_done_i in the same cycle with frame_busy=1: go directly to SWAP (done at N+1), not PEND.
  - wr_commit_i while in PEND or SWAP: ignored (coalesced), and ovr_o set.
  - wr_commit_i in the same cycle as an accepted write: the write lands in the old back bank before the swap.
  - rd_en_i during the SWAP cycle: reads the old front bank; the toggle takes effect next cycle.
  - rst_i mid-operation: pending commit discarded, banks return to front=0, no wr_done_o pulse. RAM contents are not cleared.
  - Address arithmetic: no wrap logic; addresses are exactly ADDR_W bits, and the bank bit is the MSB.

Decomposition:
- Shared package ws281x_pkg:
  - ADDR_W and DATA_W defaults.
  - arb_state_t enum {IDLE, PEND, SWAP}.
- Optional sub-module ws281x_bank_sel: holds front-bank toggle, frame_busy and the FSM. ws281x_ram_arb wraps it with the combinational port mux.

Test Plan:
- Reset, then 64 writes (addr 0..63, data 32'haaaa_cccc + addr), rd_en_i idle -> every write accepted 1/cycle; ram_addr_o = {1, addr}; ram_we_o=1.
- wr_commit_i with frame_busy=0 -> wr_done_o pulses exactly one cycle later; then rd_en_i addr 5 -> ram_addr_o=7'b0_000101... (front=1, so 7'h45); rd_data_o = 32'haaaa_ccd1 next cycle.
- rd_en_i and wr_vld_i asserted together for 10 cycles -> wr_rdy_o=0 throughout; no write reaches RAM; the writes complete in the 10 cycles after rd_en_i drops.
- Commit while frame_busy=1 -> wr_rdy_o=0 until rd_frame_done_i; wr_done_o one cycle after rd_frame_done_i; a second commit in PEND sets ovr_o=1 and yields only one wr_done_o.
- wr_commit_i and rd_frame_done_i in the same cycle -> wr_done_o next cycle; state never enters PEND.
- rst_i asserted in PEND -> wr_done_o never pulses; front bank reads return bank 0 (ram_addr_o MSB=0); ovr_o=0.
